dco_ctrl: RTL

- Digital loop controller that drives the DCO's 64-bit thermometer control word and its enable.
- Consumes registered bang-bang phase decisions (up/dn) derived from the DCO phases sampled on refclk.
- Integrates those decisions into a code and reports lock.
- Runs entirely in the refclk domain and sits between the phase sampler and the dco ctrl/enable inputs.

---
 rtl/dco_pkg.sv | 48 ++++
 rtl/dco_therm_enc.sv | 12 +
 rtl/dco_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dco_pkg.sv
// Shared types and helpers for the DCO loop controller: state/direction enums,
// control-word sizing, thermometer encoding and saturating code arithmetic.
package dco_pkg;

  localparam int NCTRL = 64;
  localparam int CW    = $clog2(NCTRL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } dir_t;

  function automatic logic [NCTRL-1:0] therm_enc(input logic [CW-1:0] c);
    logic [NCTRL-1:0] t;
    for (int i = 0; i < NCTRL; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  // Steps the code by +/-step and clamps to 0..NCTRL; never wraps.
  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c, input dir_t d,
                                             input int step);
    int v;
    v = int'(c);
    if (d == UP) begin
      v = v + step;
    end else if (d == DN) begin
      v = v - step;
    end
    if (v < 0) begin
      v = 0;
    end
    if (v > NCTRL) begin
      v = NCTRL;
    end
    return CW'(v);
  endfunction

endpackage

// File: rtl/dco_therm_enc.sv
// Combinational code -> NCTRL-bit thermometer encoder (therm[i]=1 iff i<code).
// Zero latency, no flow control; the parent registers the result.
module dco_therm_enc
  import dco_pkg::*;
(
  input  logic [CW-1:0]    code,
  output logic [NCTRL-1:0] therm
);

  assign therm = therm_enc(code);

endmodule

// File: rtl/dco_ctrl.sv
// Bang-bang DCO loop controller: integrates up/dn decisions into a thermometer word, 1-cycle latency,
// no backpressure (every dec_valid is consumed). Define DCO_CTRL_DITHER_EN for LSB dither in LOCKED.
module dco_ctrl
  import dco_pkg::*;
#(
  parameter int INIT_CODE  = 32,
  parameter int ACQ_STEP   = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_RUN = 3
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             start,
  input  logic             dec_valid,
  input  logic             up,
  input  logic             dn,
  output logic             enable,
  output logic [NCTRL-1:0] ctrl,
  output logic [CW-1:0]    code,
  output logic             locked,
  output logic [1:0]       state
);

  localparam int AW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(UNLOCK_RUN + 1);
  localparam logic [CW-1:0] INIT_C = CW'(INIT_CODE);

  state_t           st, st_nxt;
  dir_t             last_dir, last_nxt, dir;
  logic [AW-1:0]    alt_cnt, alt_nxt;
  logic [RW-1:0]    run_cnt, run_nxt;
  logic [CW-1:0]    code_nxt, enc_code;
  logic             lock_nxt;
  logic             rev, same;
  logic [NCTRL-1:0] therm_w;
`ifdef DCO_CTRL_DITHER_EN
  logic             dith, dith_nxt;
`endif

  always_comb begin
    dir = NONE;
    if (dec_valid && up && !dn) begin
      dir = UP;
    end else if (dec_valid && dn && !up) begin
      dir = DN;
    end
    rev  = (dir != NONE) && (last_dir != NONE) && (dir != last_dir);
    same = (dir != NONE) && (dir == last_dir);

    st_nxt   = st;
    code_nxt = code;
    last_nxt = last_dir;
    alt_nxt  = alt_cnt;
    run_nxt  = run_cnt;
    lock_nxt = locked;

    // Dropping start wins over any decision presented in the same cycle.
    if (!start) begin
      st_nxt   = IDLE;
      code_nxt = INIT_C;
      last_nxt = NONE;
      alt_nxt  = '0;
      run_nxt  = '0;
      lock_nxt = 1'b0;
    end else begin
      case (st)
        IDLE: begin
          st_nxt   = ACQUIRE;
          code_nxt = INIT_C;
        end
        ACQUIRE: begin
          if (dir != NONE) begin
            code_nxt = sat_step(code, dir, ACQ_STEP);
            last_nxt = dir;
            if (rev) begin
              st_nxt  = TRACK;
              alt_nxt = AW'(1);
            end
          end
        end
        TRACK: begin
          if (dir != NONE) begin
            code_nxt = sat_step(code, dir, 1);
            last_nxt = dir;
            if (!rev) begin
              alt_nxt = '0;
            end else if (int'(alt_cnt) + 1 >= LOCK_CNT) begin
              st_nxt   = LOCKED;
              lock_nxt = 1'b1;
              alt_nxt  = '0;
              run_nxt  = '0;
            end else begin
              alt_nxt = alt_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (dir != NONE) begin
            code_nxt = sat_step(code, dir, 1);
            last_nxt = dir;
            if (!same) begin
              run_nxt = '0;
            end else if (int'(run_cnt) + 1 >= UNLOCK_RUN) begin
              st_nxt   = TRACK;
              lock_nxt = 1'b0;
              alt_nxt  = '0;
              run_nxt  = '0;
            end else begin
              run_nxt = run_cnt + 1'b1;
            end
          end
        end
      endcase
    end

`ifdef DCO_CTRL_DITHER_EN
    // Phase 0 on the first LOCKED cycle, then toggles every refclk while LOCKED.
    dith_nxt = (st_nxt == LOCKED) && (st == LOCKED) && !dith;
    enc_code = dith_nxt ? sat_step(code_nxt, UP, 1) : code_nxt;
`else
    enc_code = code_nxt;
`endif
  end

  dco_therm_enc u_therm_enc (
    .code  (enc_code),
    .therm (therm_w)
  );

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      code     <= INIT_C;
      ctrl     <= therm_enc(INIT_C);
      enable   <= 1'b0;
      locked   <= 1'b0;
      last_dir <= NONE;
      alt_cnt  <= '0;
      run_cnt  <= '0;
`ifdef DCO_CTRL_DITHER_EN
      dith     <= 1'b0;
`endif
    end else begin
      st       <= st_nxt;
      code     <= code_nxt;
      ctrl     <= therm_w;
      enable   <= (st_nxt != IDLE);
      locked   <= lock_nxt;
      last_dir <= last_nxt;
      alt_cnt  <= alt_nxt;
      run_cnt  <= run_nxt;
`ifdef DCO_CTRL_DITHER_EN
      dith     <= dith_nxt;
`endif
    end
  end

  assign state = st;

endmodule
